button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Conditions a raw push-button input before it reaches the press-counting logic. The block synchronises the input, debounces it with a state machine and counter, and emits single-cycle press, release and auto-repeat pulses. The combined step_pulse drives the downstream counter's increment enable directly, so no separate shift-register debounce or edge detector is needed.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on btn_in; legal range 2..4
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a press or release (10 ms at 100 MHz); must be >= 1
REPEAT_DELAY, 50000000, cycles the button must be held before the first auto-repeat pulse (500 ms); must be >= 1
REPEAT_RATE, 10000000, cycles between later auto-repeat pulses (100 ms); must be >= 1

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-low reset
btn_in  in  1  raw push-button level, asynchronous to clk; 1 = pressed
rep_en  in  1  auto-repeat enable; sampled every cycle
btn_level  out  1  debounced button level
press_pulse  out  1  one-cycle pulse when a press is accepted
release_pulse  out  1  one-cycle pulse when a release is accepted
repeat_pulse  out  1  one-cycle auto-repeat pulse
step_pulse  out  1  press_pulse OR repeat_pulse

Behaviour:
- Reset: when rst = 0, every flop clears immediately: synchroniser, state (IDLE), counter, and all outputs = 0. Reset deasserts on the clk edge.
- Synchroniser: s is the output of the SYNC_STAGES-deep flop chain. All FSM decisions use s only.
- Counter: a single counter, width = clog2 of max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE). It is cleared to 0 on every state transition. The terminal-count compare never wraps.
- FSM states and transitions:
  - IDLE (btn_level = 0): s = 1 -> DB_PRESS.
  - DB_PRESS (btn_level = 0):
    - s = 0 -> IDLE; bounce rejected, no pulse.
    - s = 1 and cnt = DEBOUNCE_CYCLES-1 -> HELD.
    - otherwise cnt increments.
  - HELD (btn_level = 1):
    - s = 0 -> DB_REL.
    - rep_en = 1 and cnt = REPEAT_DELAY-1 -> RPT.
    - otherwise cnt increments, saturating at REPEAT_DELAY-1.
  - RPT (btn_level = 1):
    - s = 0 -> DB_REL.
    - cnt = REPEAT_RATE-1 -> stay in RPT, cnt = 0, repeat_pulse.
    - rep_en = 0 -> HELD.
  - DB_REL (btn_level = 1):
    - s = 1 -> HELD, cnt = 0; release bounce rejected and the repeat delay restarts.
    - s = 0 and cnt = DEBOUNCE_CYCLES-1 -> IDLE.
- Registered pulses, each high for exactly one cycle:
  - press_pulse in the first cycle in HELD when entered from DB_PRESS. It is not asserted on re-entry to HELD from DB_REL.
  - repeat_pulse in the first cycle after entering RPT, and in the cycle after each RPT terminal count.
  - release_pulse in the first cycle in IDLE when entered from DB_REL.
- btn_level is registered and changes in the same cycle as press_pulse and release_pulse.
- step_pulse is combinational from the registered pulses. press_pulse and repeat_pulse are never high in the same cycle.
- Latency: from btn_in rising (stable) to press_pulse = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles. Release latency is the same.
- Auto-repeat spacing: first repeat_pulse REPEAT_DELAY cycles after press_pulse, then every REPEAT_RATE cycles.
- Boundary conditions:
  - rep_en dropping while in RPT stops further repeats; the block remains pressed.
  - Reset mid-press gives no release_pulse.
  - A button held through reset release produces a normal press_pulse after the press latency.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, rep_en = 0 unless stated.
1. Clean press: btn_in 0 -> 1, held 20 cycles -> press_pulse high exactly 1 cycle, 7 cycles after the edge; btn_level = 1 from that cycle; step_pulse matches press_pulse.
2. Bounce reject: btn_in high for 3 cycles, low 2 cycles, repeated 5 times -> no pulses, btn_level stays 0.
3. Release with bounce: while pressed, btn_in goes low 2 cycles, high 1 cycle, then low 10 cycles -> exactly one release_pulse, 7 cycles after the final falling edge; no second press_pulse.
4. Auto-repeat: rep_en = 1, hold 30 cycles after press_pulse -> repeat_pulse at press+10, +13, +16, +19, +22, +25, +28; step_pulse counts 8 total.
5. Repeat disable: rep_en drops to 0 after the second repeat_pulse -> no further repeat_pulse; btn_level stays 1 until release.
6. Reset mid-operation: rst = 0 asserted while in RPT -> all outputs 0 immediately, no release_pulse; btn_in held through rst = 1 -> press_pulse 7 cycles after reset release.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw button/enable in, debounced level and pulses out.
interface button_conditioner_if;
    logic btn_in;
    logic rep_en;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic step_pulse;

    modport master (
        output btn_in, rep_en,
        input  btn_level, press_pulse, release_pulse, repeat_pulse, step_pulse
    );

    modport slave (
        input  btn_in, rep_en,
        output btn_level, press_pulse, release_pulse, repeat_pulse, step_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces a push-button, producing press/release/auto-repeat pulses
// and a combined step pulse for the downstream press counter.
module button_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_RATE     = 10000000
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    localparam int unsigned MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CNT = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int unsigned CNT_W   = ($clog2(MAX_CNT) < 1) ? 1 : $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DB_PRESS,
        S_HELD,
        S_RPT,
        S_DB_REL
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_btn_level;
    logic                   r_press_pulse;
    logic                   r_release_pulse;
    logic                   r_repeat_pulse;

    logic                   w_s;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_level_nxt;
    logic                   w_press_nxt;
    logic                   w_release_nxt;
    logic                   w_repeat_nxt;

    // Metastability chain; only its last stage feeds the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.btn_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_btn_level     <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_repeat_pulse  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_btn_level     <= w_level_nxt;
            r_press_pulse   <= w_press_nxt;
            r_release_pulse <= w_release_nxt;
            r_repeat_pulse  <= w_repeat_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_repeat_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_s) w_state_nxt = S_DB_PRESS;
            end
            S_DB_PRESS: begin
                if (!w_s) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = S_HELD;
                    w_press_nxt = 1'b1;
                end
            end
            S_HELD: begin
                if (!w_s) begin
                    w_state_nxt = S_DB_REL;
                end else if (bus.rep_en && (r_cnt == DELAY_LAST)) begin
                    w_state_nxt  = S_RPT;
                    w_repeat_nxt = 1'b1;
                end else if (r_cnt == DELAY_LAST) begin
                    w_cnt_nxt = r_cnt;
                end
            end
            S_RPT: begin
                if (!w_s) begin
                    w_state_nxt = S_DB_REL;
                end else if (r_cnt == RATE_LAST) begin
                    w_cnt_nxt    = '0;
                    w_repeat_nxt = 1'b1;
                end else if (!bus.rep_en) begin
                    w_state_nxt = S_HELD;
                end
            end
            S_DB_REL: begin
                if (w_s) begin
                    w_state_nxt = S_HELD;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_release_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // One shared counter: every state change restarts it.
        if (w_state_nxt != r_state) w_cnt_nxt = '0;

        w_level_nxt = (w_state_nxt == S_HELD) || (w_state_nxt == S_RPT) || (w_state_nxt == S_DB_REL);
    end

    assign bus.btn_level     = r_btn_level;
    assign bus.press_pulse   = r_press_pulse;
    assign bus.release_pulse = r_release_pulse;
    assign bus.repeat_pulse  = r_repeat_pulse;
    assign bus.step_pulse    = r_press_pulse | r_repeat_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulses are queued with their cycle
// when stimulus is driven and every output is compared on each falling clock edge.
module tb_button_conditioner;

    localparam int unsigned DB    = 4;
    localparam int unsigned DLY   = 10;
    localparam int unsigned RATE  = 3;
    localparam int unsigned LAT   = 2 + DB + 1;  // sync stages + debounce + output register
    localparam int unsigned REACT = 2 + 1;       // edges until the FSM acts on a new level

    typedef enum int {EV_PRESS, EV_REL, EV_RPT} ev_kind_t;
    typedef struct {
        int unsigned cyc;
        ev_kind_t    kind;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    ev_t         sb[$];
    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned n_step   = 0;
    int unsigned win_lo   = 0;
    int unsigned win_hi   = 0;
    logic        exp_level = 1'b0;
    logic        m_p, m_r, m_t;
    ev_t         m_ev;
    int unsigned p, r;

    always #5 clk = ~clk;

    button_conditioner_if bus ();

    button_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (DLY),
        .REPEAT_RATE    (RATE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int unsigned obs, input int unsigned expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    function automatic void push(input int unsigned c, input ev_kind_t k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        sb.push_back(e);
    endfunction

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_level"},   bus.btn_level,     1'b0);
        chk({pfx, "_press"},   bus.press_pulse,   1'b0);
        chk({pfx, "_release"}, bus.release_pulse, 1'b0);
        chk({pfx, "_repeat"},  bus.repeat_pulse,  1'b0);
        chk({pfx, "_step"},    bus.step_pulse,    1'b0);
    endtask

    // Scoreboard: pop events due this cycle and compare every output.
    always @(negedge clk) begin
        m_p = 1'b0;
        m_r = 1'b0;
        m_t = 1'b0;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            m_ev = sb.pop_front();
            case (m_ev.kind)
                EV_PRESS: m_p = 1'b1;
                EV_REL:   m_r = 1'b1;
                default:  m_t = 1'b1;
            endcase
        end
        if (!rst)     exp_level = 1'b0;
        else if (m_p) exp_level = 1'b1;
        else if (m_r) exp_level = 1'b0;
        chk("press_pulse",   bus.press_pulse,   m_p);
        chk("release_pulse", bus.release_pulse, m_r);
        chk("repeat_pulse",  bus.repeat_pulse,  m_t);
        chk("step_pulse",    bus.step_pulse,    m_p | m_t);
        chk("btn_level",     bus.btn_level,     exp_level);
        if (bus.step_pulse && cyc >= win_lo && cyc <= win_hi) n_step++;
    end

    initial begin
        rst        = 1'b0;
        bus.btn_in = 1'b0;
        bus.rep_en = 1'b0;
        #2;
        chk_all_zero("reset");
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(3);

        // Clean press, held 20 cycles.
        bus.btn_in = 1'b1;
        push(cyc + LAT, EV_PRESS);
        wait_cyc(20);

        // Release with a bounce; only the final falling edge counts.
        bus.btn_in = 1'b0;
        wait_cyc(2);
        bus.btn_in = 1'b1;
        wait_cyc(1);
        bus.btn_in = 1'b0;
        push(cyc + LAT, EV_REL);
        wait_cyc(12);

        // Press bounce: 3 high / 2 low never reaches the debounce count.
        for (int i = 0; i < 5; i++) begin
            bus.btn_in = 1'b1;
            wait_cyc(3);
            bus.btn_in = 1'b0;
            wait_cyc(2);
        end
        wait_cyc(10);
        chk("bounce_level", bus.btn_level, 1'b0);

        // Auto-repeat: held 30 cycles past the press, then released.
        bus.rep_en = 1'b1;
        bus.btn_in = 1'b1;
        p = cyc + LAT;
        r = p + 30;
        push(p, EV_PRESS);
        for (int unsigned e = p + DLY; e < r + REACT; e += RATE) push(e, EV_RPT);
        win_lo = p;
        win_hi = p + 29;
        wait_cyc(r - cyc);
        bus.btn_in = 1'b0;
        push(cyc + LAT, EV_REL);
        wait_cyc(12);
        chk_int("step_count", n_step, 8);

        // Repeat disable after the second repeat pulse.
        bus.btn_in = 1'b1;
        p = cyc + LAT;
        push(p, EV_PRESS);
        push(p + DLY, EV_RPT);
        push(p + DLY + RATE, EV_RPT);
        wait_cyc(p + DLY + RATE - cyc);
        bus.rep_en = 1'b0;
        wait_cyc(p + 30 - cyc);
        chk("disable_level", bus.btn_level, 1'b1);
        bus.btn_in = 1'b0;
        push(cyc + LAT, EV_REL);
        wait_cyc(12);

        // Reset while repeating, button held through reset release.
        bus.rep_en = 1'b1;
        bus.btn_in = 1'b1;
        p = cyc + LAT;
        push(p, EV_PRESS);
        push(p + DLY, EV_RPT);
        wait_cyc(p + DLY - cyc);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        wait_cyc(3);
        rst = 1'b1;
        bus.rep_en = 1'b0;
        push(cyc + LAT, EV_PRESS);
        wait_cyc(15);
        bus.btn_in = 1'b0;
        push(cyc + LAT, EV_REL);
        wait_cyc(12);

        chk_int("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
